// File: rtl/mvau_thresh_act_if.sv
// mvau_thresh_act_if
//
// Groups the stream and threshold-programming signals of mvau_thresh_act.
//
// Signals:
//   in_v / in_rdy / in_dat        upstream accumulator beat handshake (PE lanes of TA bits)
//   thr_wen / thr_nf / thr_pe /   threshold register-file write port
//   thr_idx / thr_wdat
//   out_v / out_rdy / out_dat     downstream activation beat handshake (PE lanes of OB bits)
//   nf_cnt                        fold index that the next accepted beat will use (debug)
//
// Modports:
//   master  the environment: drives beats, threshold writes and out_rdy
//   slave   the activation block itself
interface mvau_thresh_act_if #(
    parameter int PE = 2,
    parameter int NF = 4,
    parameter int TA = 16,
    parameter int NT = 3
);
    localparam int OB  = $clog2(NT + 1);
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
    localparam int PEW = (PE > 1) ? $clog2(PE) : 1;
    localparam int NTW = (NT > 1) ? $clog2(NT) : 1;

    logic               in_v;
    logic               in_rdy;
    logic [PE*TA-1:0]   in_dat;

    logic               thr_wen;
    logic [NFW-1:0]     thr_nf;
    logic [PEW-1:0]     thr_pe;
    logic [NTW-1:0]     thr_idx;
    logic [TA-1:0]      thr_wdat;

    logic               out_v;
    logic               out_rdy;
    logic [PE*OB-1:0]   out_dat;

    logic [NFW-1:0]     nf_cnt;

    modport master (
        output in_v, in_dat,
        output thr_wen, thr_nf, thr_pe, thr_idx, thr_wdat,
        output out_rdy,
        input  in_rdy, out_v, out_dat, nf_cnt
    );

    modport slave (
        input  in_v, in_dat,
        input  thr_wen, thr_nf, thr_pe, thr_idx, thr_wdat,
        input  out_rdy,
        output in_rdy, out_v, out_dat, nf_cnt
    );
endinterface

// File: rtl/mvau_thresh_act.sv
// mvau_thresh_act
//
// Multi-threshold activation stage behind the matrix-vector stream unit.
// Each accepted beat carries PE accumulator lanes; every lane is compared
// against the NT thresholds of its neuron for the current neuron fold and
// the number of thresholds met is emitted as an OB-bit activation.
// Two pipeline stages: S1 latches the beat and its thresholds, S2 holds the
// registered counts.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mvau_thresh_act_if.slave (beat handshakes, threshold writes, nf_cnt)
//
// Build option:
//   MVAU_THRESH_SIGNED_EN  when defined, lanes and thresholds are two's
//                          complement and compared signed; otherwise unsigned.
module mvau_thresh_act #(
    parameter int PE = 2,
    parameter int NF = 4,
    parameter int TA = 16,
    parameter int NT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mvau_thresh_act_if.slave  bus
);
    localparam int OB  = $clog2(NT + 1);
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;

    // A threshold at the largest representable value can only be met by an
    // input equal to it, so a fresh store yields near-zero activations.
`ifdef MVAU_THRESH_SIGNED_EN
    localparam logic [TA-1:0] THR_MAX = {1'b0, {(TA-1){1'b1}}};
`else
    localparam logic [TA-1:0] THR_MAX = {TA{1'b1}};
`endif

    logic [TA-1:0]      thr_q   [NF][PE][NT];
    logic [NFW-1:0]     nfCnt_q;
    logic [NFW-1:0]     nfCnt_d;

    logic               s1Vld_q;
    logic [PE*TA-1:0]   s1Acc_q;
    logic [TA-1:0]      s1Thr_q [PE][NT];

    logic               outVld_q;
    logic [PE*OB-1:0]   outDat_q;
    logic [PE*OB-1:0]   outDat_d;
    logic [OB-1:0]      laneCnt [PE];

    logic               en;
    logic               accept;
    logic               wrInRange;

    function automatic logic geThr(input logic [TA-1:0] a, input logic [TA-1:0] t);
`ifdef MVAU_THRESH_SIGNED_EN
        return $signed(a) >= $signed(t);
`else
        return a >= t;
`endif
    endfunction

    // The whole pipeline moves together: it may advance whenever the output
    // register is empty or being drained this cycle.
    assign en          = !outVld_q || bus.out_rdy;
    assign accept      = bus.in_v && en;
    assign bus.in_rdy  = en;
    assign bus.out_v   = outVld_q;
    assign bus.out_dat = outDat_q;
    assign bus.nf_cnt  = nfCnt_q;

    // Index fields may be wider than the populated range (non-power-of-two
    // sizes), so writes beyond the store are dropped rather than aliased.
    assign wrInRange = (int'(bus.thr_nf) < NF) && (int'(bus.thr_pe) < PE) &&
                       (int'(bus.thr_idx) < NT);

    // Fold counter: one step per accepted beat, wrapping after the last fold.
    always_comb begin
        nfCnt_d = nfCnt_q;
        if (accept) begin
            if (nfCnt_q == NFW'(NF - 1)) begin
                nfCnt_d = '0;
            end else begin
                nfCnt_d = nfCnt_q + NFW'(1);
            end
        end
    end

    // Threshold register file. S1 reads the pre-edge contents, so a write in
    // the same cycle as an accepted beat is only seen by later beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < NF; f++) begin
                for (int p = 0; p < PE; p++) begin
                    for (int i = 0; i < NT; i++) begin
                        thr_q[f][p][i] <= THR_MAX;
                    end
                end
            end
        end else if (bus.thr_wen && wrInRange) begin
            thr_q[bus.thr_nf][bus.thr_pe][bus.thr_idx] <= bus.thr_wdat;
        end
    end

    // S2 combinational part: per lane, count how many latched thresholds the
    // accumulator meets. A plain population count, so threshold order is free.
    always_comb begin
        outDat_d = '0;
        for (int p = 0; p < PE; p++) begin
            laneCnt[p] = '0;
            for (int i = 0; i < NT; i++) begin
                if (geThr(s1Acc_q[p*TA +: TA], s1Thr_q[p][i])) begin
                    laneCnt[p] = laneCnt[p] + OB'(1);
                end
            end
            outDat_d[p*OB +: OB] = laneCnt[p];
        end
    end

    // Pipeline registers and fold counter. S1 captures the beat together with
    // its fold's thresholds so later store writes cannot disturb it; with en
    // low everything holds, which keeps out_dat stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nfCnt_q  <= '0;
            s1Vld_q  <= 1'b0;
            s1Acc_q  <= '0;
            outVld_q <= 1'b0;
            outDat_q <= '0;
            for (int p = 0; p < PE; p++) begin
                for (int i = 0; i < NT; i++) begin
                    s1Thr_q[p][i] <= '0;
                end
            end
        end else begin
            nfCnt_q <= nfCnt_d;
            if (en) begin
                s1Vld_q  <= bus.in_v;
                outVld_q <= s1Vld_q;
                outDat_q <= outDat_d;
                if (bus.in_v) begin
                    s1Acc_q <= bus.in_dat;
                    for (int p = 0; p < PE; p++) begin
                        for (int i = 0; i < NT; i++) begin
                            s1Thr_q[p][i] <= thr_q[nfCnt_q][p][i];
                        end
                    end
                end
            end
        end
    end
endmodule
